// File: rtl/ctrl_pkg.sv
// ctrl_pkg: state, opcode and mux-select encodings shared by the multicycle control path
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_LUI      = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;

    function automatic logic is_legal_op(input logic [6:0] op);
        return op inside {OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ, OP_LUI};
    endfunction

endpackage

// File: rtl/ctrl_outdec.sv
// ctrl_outdec: Moore decode of control state into mux selects and raw (ungated) strobes
module ctrl_outdec
    import ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_update,
    output logic       branch,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op
);

    // per-state output table; anything not set for a state stays 0
    always_comb begin
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RD2;
        alu_op     = ALU_ADD;
        case (state)
            S_FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURES;
                ir_write   = mem_ready;
                pc_update  = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD:  adr_src = 1'b1;
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = SRCA_RD1;
                alu_op    = ALU_FUNCT;
            end
            S_EXECUTEI: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_FUNCT;
            end
            S_ALUWB:    reg_write = 1'b1;
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_update = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = SRCA_RD1;
                alu_op    = ALU_SUB;
                branch    = 1'b1;
            end
            S_LUI: begin
                result_src = RES_IMM;
                reg_write  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: main sequencer for the multicycle RISC-V datapath
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic       illegal_op
);

    state_t state, next;
    logic   mem_write_raw, ir_write_raw, reg_write_raw, pc_update, branch;

    // state register; reset aborts any instruction in flight and returns to fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= next;
    end

    // next-state: op is only looked at in DECODE and MEMADR
    always_comb begin
        next = S_FETCH;
        case (state)
            S_FETCH:    next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: next = S_MEMADR;
                    OP_R:         next = S_EXECUTER;
                    OP_I:         next = S_EXECUTEI;
                    OP_JAL:       next = S_JAL;
                    OP_BEQ:       next = S_BEQ;
                    OP_LUI:       next = S_LUI;
                    default:      next = S_FETCH;
                endcase
            end
            S_MEMADR:   next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  next = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: next = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER, S_EXECUTEI, S_JAL: next = S_ALUWB;
            default:    next = S_FETCH;
        endcase
    end

    ctrl_outdec u_outdec (
        .state      (state),
        .mem_ready  (mem_ready),
        .adr_src    (adr_src),
        .mem_write  (mem_write_raw),
        .ir_write   (ir_write_raw),
        .pc_update  (pc_update),
        .branch     (branch),
        .reg_write  (reg_write_raw),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op)
    );

    // strobes are held off while reset is low so nothing commits during an abort
    always_comb begin
        pc_write   = rst_n & (pc_update | (branch & zero));
        mem_write  = rst_n & mem_write_raw;
        ir_write   = rst_n & ir_write_raw;
        reg_write  = rst_n & reg_write_raw;
        illegal_op = rst_n & (state == S_DECODE) & ~is_legal_op(op);
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: directed per-cycle checks of the control FSM outputs
module tb_multicycle_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    int         tests = 0;
    int         fails = 0;

    multicycle_ctrl_fsm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .adr_src    (adr_src),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_write  (reg_write),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    // observed vector: pcw adr mw irw rs[2] a[2] b[2] aop[2] rw ill
    logic [13:0] outs;
    assign outs = {pc_write, adr_src, mem_write, ir_write, result_src,
                   alu_src_a, alu_src_b, alu_op, reg_write, illegal_op};

    function automatic logic [13:0] e(input logic pcw, adr, mw, irw,
                                      input logic [1:0] rs, a, b, aop,
                                      input logic rw, ill);
        return {pcw, adr, mw, irw, rs, a, b, aop, rw, ill};
    endfunction

    // hand-written expected vectors per state
    logic [13:0] X_RST, X_FETCH1, X_FETCH0, X_DECODE, X_MEMADR, X_MEMREAD, X_MEMWB, X_MEMWRITE;
    logic [13:0] X_EXR, X_EXI, X_ALUWB, X_JAL, X_BEQ1, X_BEQ0, X_LUI, X_ILL;

    task automatic chk(input string tag, input logic [13:0] expv);
        #1;
        tests++;
        assert (outs === expv)
        else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, outs, expv);
        end
    endtask

    task automatic step(input string tag, input logic [13:0] expv);
        chk(tag, expv);
        @(posedge clk);
        #1;
    endtask

    initial begin
        X_RST      = e(0,0,0,0, 2'b10, 2'b00, 2'b10, 2'b00, 0,0);
        X_FETCH1   = e(1,0,0,1, 2'b10, 2'b00, 2'b10, 2'b00, 0,0);
        X_FETCH0   = e(0,0,0,0, 2'b10, 2'b00, 2'b10, 2'b00, 0,0);
        X_DECODE   = e(0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 0,0);
        X_ILL      = e(0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 0,1);
        X_MEMADR   = e(0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00, 0,0);
        X_MEMREAD  = e(0,1,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 0,0);
        X_MEMWB    = e(0,0,0,0, 2'b01, 2'b00, 2'b00, 2'b00, 1,0);
        X_MEMWRITE = e(0,1,1,0, 2'b00, 2'b00, 2'b00, 2'b00, 0,0);
        X_EXR      = e(0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b10, 0,0);
        X_EXI      = e(0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b10, 0,0);
        X_ALUWB    = e(0,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 1,0);
        X_JAL      = e(1,0,0,0, 2'b00, 2'b01, 2'b10, 2'b00, 0,0);
        X_BEQ1     = e(1,0,0,0, 2'b00, 2'b10, 2'b00, 2'b01, 0,0);
        X_BEQ0     = e(0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b01, 0,0);
        X_LUI      = e(0,0,0,0, 2'b11, 2'b00, 2'b00, 2'b00, 1,0);

        // reset with mem_ready high: strobes must stay low
        rst_n = 1'b0; op = 7'b0000011; zero = 1'b0; mem_ready = 1'b1;
        chk("reset", X_RST);
        @(posedge clk); #1;
        chk("reset_hold", X_RST);
        rst_n = 1'b1;

        // lw, mem_ready high: 5 cycles; op changed in MEMREAD must be ignored
        step("lw_fetch", X_FETCH1);
        step("lw_decode", X_DECODE);
        step("lw_memadr", X_MEMADR);
        op = 7'b0100011;
        step("lw_memread", X_MEMREAD);
        step("lw_memwb", X_MEMWB);

        // sw with two stall cycles in MEMWRITE
        op = 7'b0100011;
        step("sw_fetch", X_FETCH1);
        step("sw_decode", X_DECODE);
        step("sw_memadr", X_MEMADR);
        mem_ready = 1'b0;
        step("sw_memwrite_stall1", X_MEMWRITE);
        step("sw_memwrite_stall2", X_MEMWRITE);
        mem_ready = 1'b1;
        step("sw_memwrite_done", X_MEMWRITE);

        // fetch stall, then beq taken
        mem_ready = 1'b0; op = 7'b1100011;
        step("fetch_stall", X_FETCH0);
        mem_ready = 1'b1;
        step("beq1_fetch", X_FETCH1);
        step("beq1_decode", X_DECODE);
        zero = 1'b1;
        step("beq_taken", X_BEQ1);
        zero = 1'b0;

        // beq not taken
        step("beq0_fetch", X_FETCH1);
        step("beq0_decode", X_DECODE);
        step("beq_not_taken", X_BEQ0);

        // lui
        op = 7'b0110111;
        step("lui_fetch", X_FETCH1);
        step("lui_decode", X_DECODE);
        step("lui_wb", X_LUI);

        // R-type
        op = 7'b0110011;
        step("r_fetch", X_FETCH1);
        step("r_decode", X_DECODE);
        step("r_exec", X_EXR);
        step("r_wb", X_ALUWB);

        // I-ALU
        op = 7'b0010011;
        step("i_fetch", X_FETCH1);
        step("i_decode", X_DECODE);
        step("i_exec", X_EXI);
        step("i_wb", X_ALUWB);

        // jal
        op = 7'b1101111;
        step("jal_fetch", X_FETCH1);
        step("jal_decode", X_DECODE);
        step("jal_exec", X_JAL);
        step("jal_wb", X_ALUWB);

        // illegal opcode: one pulse in DECODE, straight back to FETCH
        op = 7'b1111111;
        step("ill_fetch", X_FETCH1);
        step("ill_decode", X_ILL);
        mem_ready = 1'b0;
        step("ill_back_fetch", X_FETCH0);

        // reset during a MEMWRITE stall
        mem_ready = 1'b1; op = 7'b0100011;
        step("sw2_fetch", X_FETCH1);
        step("sw2_decode", X_DECODE);
        step("sw2_memadr", X_MEMADR);
        mem_ready = 1'b0;
        chk("sw2_memwrite_stall", X_MEMWRITE);
        rst_n = 1'b0;
        chk("abort_async", X_RST);
        @(posedge clk); #1;
        chk("abort_hold", X_RST);
        rst_n = 1'b1;
        step("post_rst_fetch_stall", X_FETCH0);
        mem_ready = 1'b1;
        step("post_rst_fetch", X_FETCH1);
        step("post_rst_decode", X_DECODE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
# multicycle_ctrl_fsm

Main control state machine for the multicycle RISC-V datapath. It decodes the opcode and sequences each instruction through fetch, decode, execute, memory and writeback. On every cycle it drives the select and strobe signals: ResultSrc, ALUSrcA/B, AdrSrc, ALUOp, and the register, memory, IR and PC write enables. It also stalls on a memory ready handshake.

## Interface
Parameters:
- None. All encodings come from `ctrl_pkg`.

Ports:
- clk  in  1  sole clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- op  in  7  opcode field from the instruction register
- zero  in  1  ALU zero flag (BEQ compare)
- mem_ready  in  1  memory has completed the current read or write this cycle
- pc_write  out  1  PC load strobe = pc_update | (branch & zero)
- adr_src  out  1  0 = PC, 1 = ALUOut to memory address
- mem_write  out  1  data memory write strobe
- ir_write  out  1  instruction register load strobe
- result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
- alu_src_a  out  2  00 PC, 01 OldPC, 10 RD1
- alu_src_b  out  2  00 RD2, 01 ImmExt, 10 constant 4
- alu_op  out  2  00 add, 01 subtract, 10 funct-decoded
- reg_write  out  1  register file write strobe
- illegal_op  out  1  one-cycle pulse on an unrecognised opcode

## Operation
- Opcodes:
  - lw 0000011
  - sw 0100011
  - R-type 0110011
  - I-ALU 0010011
  - jal 1101111
  - beq 1100011
  - lui 0110111
- Moore outputs are decoded from state. Every output not listed for a state is 0.
- States, their outputs, and next state:
  - FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10. ir_write=pc_update=mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
  - DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target into ALUOut). Next state by op:
    - lw/sw → MEMADR
    - R → EXECUTER
    - I → EXECUTEI
    - jal → JAL
    - beq → BEQ
    - lui → LUI
    - other → FETCH, with illegal_op=1 for that cycle
  - MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Next is MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: adr_src=1, result_src=00. Holds until mem_ready, then → MEMWB.
  - MEMWB: result_src=01, reg_write=1 → FETCH.
  - MEMWRITE: adr_src=1, result_src=00, mem_write=1. mem_write stays high while stalled. → FETCH on mem_ready.
  - EXECUTER: alu_src_a=10, alu_src_b=00, alu_op=10 → ALUWB.
  - EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10 → ALUWB.
  - ALUWB: result_src=00, reg_write=1 → FETCH.
  - JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1 → ALUWB.
  - BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1 → FETCH.
  - LUI: result_src=11, reg_write=1 → FETCH.
- op is sampled only in DECODE and MEMADR. Changes to op in any other state are ignored.

## Timing
- Reset: rst_n low forces the state to FETCH immediately, with no clock edge needed.
- While rst_n=0, these are forced to 0 regardless of mem_ready:
  - pc_write, ir_write, reg_write, mem_write, illegal_op
- Other outputs during reset show the FETCH decode.
- Reset asserted mid-instruction (for example during a MEMWRITE stall) aborts that instruction. mem_write must drop in the same cycle.
- Cycle counts with mem_ready tied high:
  - lw: 5
  - sw: 4
  - R/I: 4
  - jal: 4
  - beq: 3
  - lui: 3
  - illegal: 2
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- pc_write is combinational on zero in BEQ. The PC is loaded at the end of the BEQ cycle only if zero=1.
- Strobes occur exactly once per instruction:
  - ir_write and the FETCH pc_update: once per fetch, on the mem_ready cycle.
  - reg_write: once per writeback.

## Structure
- `ctrl_pkg` holds:
  - the state enum (typedef, 4-bit encoding)
  - opcode localparams
  - result_src, alu_src_a/b and alu_op encodings
- `ctrl_pkg` is shared with the result, ALU source and address muxes.
- The block has a single always_ff state register plus always_comb next-state and output logic.
- The natural split is a sub-module `ctrl_outdec` (state → output decode). It is optional.
- The ALU decoder (alu_op, funct3/7 → ALU control) remains a separate sibling and is not part of this block.

## Test plan
- lw, mem_ready=1: state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB. result_src=01 and reg_write=1 only in cycle 5.
- sw with mem_ready low for 2 cycles in MEMWRITE: mem_write=1 for 3 cycles, then FETCH. reg_write never asserted.
- beq with zero=1, then again with zero=0: pc_write=1 in the BEQ cycle only for zero=1. alu_op=01 in both cases.
- lui (op 0110111): result_src=11 and reg_write=1 in cycle 3, then back to FETCH.
- op=1111111: illegal_op pulses in DECODE, next state is FETCH, and no write strobe fires.
- rst_n dropped mid-MEMWRITE stall: mem_write goes to 0 asynchronously. After release, the first edge continues from FETCH with ir_write gated by mem_ready.
